// File: rtl/serial_add_sub_unit.sv
// Bit-serial WIDTH-bit adder/subtractor: one full adder plus a carry flip-flop,
// operands consumed LSB-first, one bit per clock, with start/busy/done handshake.
module serial_add_sub_unit #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic             subtract,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             carryOut,
   output logic             overflow,
   output logic             zero
);

   localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);

   typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] op_a_q, op_a_d;
   logic [WIDTH-1:0] op_b_q, op_b_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic [CntW-1:0]  count_q, count_d;
   logic             carry_q, carry_d;
   logic             msb_cin_q, msb_cin_d;
   logic             done_q, done_d;
   logic             carry_out_q, carry_out_d;
   logic             overflow_q, overflow_d;
   logic             zero_q, zero_d;

   // Single full adder shared by every bit position.
   logic fa_sum, fa_cout;
   assign fa_sum  = op_a_q[0] ^ op_b_q[0] ^ carry_q;
   assign fa_cout = (op_a_q[0] & op_b_q[0]) | (carry_q & (op_a_q[0] ^ op_b_q[0]));

   always_comb begin
      state_d     = state_q;
      op_a_d      = op_a_q;
      op_b_d      = op_b_q;
      result_d    = result_q;
      count_d     = count_q;
      carry_d     = carry_q;
      msb_cin_d   = msb_cin_q;
      done_d      = 1'b0;
      carry_out_d = carry_out_q;
      overflow_d  = overflow_q;
      zero_d      = zero_q;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               // Subtraction as a + ~b + 1: the +1 enters through the carry.
               op_a_d   = a;
               op_b_d   = subtract ? ~b : b;
               carry_d  = subtract;
               count_d  = '0;
               result_d = '0;
               state_d  = StShift;
            end
         end
         StShift: begin
            result_d = {fa_sum, result_q[WIDTH-1:1]};
            op_a_d   = {1'b0, op_a_q[WIDTH-1:1]};
            op_b_d   = {1'b0, op_b_q[WIDTH-1:1]};
            carry_d  = fa_cout;
            if (count_q == LastBit) begin
               msb_cin_d = carry_q;
               state_d   = StDone;
            end else begin
               count_d = count_q + 1'b1;
            end
         end
         StDone: begin
            done_d      = 1'b1;
            carry_out_d = carry_q;
            overflow_d  = msb_cin_q ^ carry_q;
            zero_d      = (result_q == '0);
            state_d     = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= StIdle;
         op_a_q      <= '0;
         op_b_q      <= '0;
         result_q    <= '0;
         count_q     <= '0;
         carry_q     <= 1'b0;
         msb_cin_q   <= 1'b0;
         done_q      <= 1'b0;
         carry_out_q <= 1'b0;
         overflow_q  <= 1'b0;
         zero_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         op_a_q      <= op_a_d;
         op_b_q      <= op_b_d;
         result_q    <= result_d;
         count_q     <= count_d;
         carry_q     <= carry_d;
         msb_cin_q   <= msb_cin_d;
         done_q      <= done_d;
         carry_out_q <= carry_out_d;
         overflow_q  <= overflow_d;
         zero_q      <= zero_d;
      end
   end

   assign busy     = (state_q == StShift);
   assign done     = done_q;
   assign result   = result_q;
   assign carryOut = carry_out_q;
   assign overflow = overflow_q;
   assign zero     = zero_q;

endmodule

// File: tb/tb_serial_add_sub_unit.sv
// Scoreboard bench for serial_add_sub_unit (WIDTH=8): directed ops push expected
// results, an independent monitor pops and compares on every done pulse.
module tb_serial_add_sub_unit;

   logic       clock = 1'b0;
   logic       reset;
   logic       start;
   logic       subtract;
   logic [7:0] a;
   logic [7:0] b;
   logic       busy;
   logic       done;
   logic [7:0] result;
   logic       carryOut;
   logic       overflow;
   logic       zero;

   typedef struct packed {
      logic [7:0] res;
      logic       co;
      logic       ov;
      logic       z;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad = 0;
   int   done_pulses = 0;

   serial_add_sub_unit #(.WIDTH(8)) dut (
      .clock    (clock),
      .reset    (reset),
      .start    (start),
      .subtract (subtract),
      .a        (a),
      .b        (b),
      .busy     (busy),
      .done     (done),
      .result   (result),
      .carryOut (carryOut),
      .overflow (overflow),
      .zero     (zero)
   );

   always #5 clock = ~clock;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
      end
   endtask

   // Monitor: compares every done pulse against the oldest expected entry.
   initial begin
      exp_t e;
      forever begin
         @(negedge clock);
         if (done === 1'b1) begin
            done_pulses++;
            if (sb.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_done: got done=1 expected no pending op (result=0x%0h)",
                        result);
            end else begin
               e = sb.pop_front();
               check("result", 32'(result), 32'(e.res));
               check("carryOut", 32'(carryOut), 32'(e.co));
               check("overflow", 32'(overflow), 32'(e.ov));
               check("zero", 32'(zero), 32'(e.z));
            end
         end
      end
   end

   // Issue one op; glitch_n > 0 pulses start (a=0xFF) at that negedge after acceptance.
   task automatic run_op(input string name, input logic [7:0] ta, input logic [7:0] tb,
                         input logic ts, input logic [7:0] er, input logic eco,
                         input logic eov, input logic ez, input int glitch_n);
      int busy_cnt = 0;
      int lat = 0;
      bit seen = 0;
      exp_t e;
      e.res = er;
      e.co  = eco;
      e.ov  = eov;
      e.z   = ez;
      @(posedge clock);
      #1;
      start    = 1'b1;
      a        = ta;
      b        = tb;
      subtract = ts;
      sb.push_back(e);
      @(posedge clock);
      #1;
      start    = 1'b0;
      a        = ~ta;
      b        = ~tb;
      subtract = ~ts;
      for (int n = 1; n <= 40; n++) begin
         @(negedge clock);
         if (glitch_n > 0 && n == glitch_n) begin
            start = 1'b1;
            a     = 8'hFF;
         end else if (glitch_n > 0 && n == glitch_n + 1) begin
            start = 1'b0;
         end
         if (busy === 1'b1) busy_cnt++;
         if (done === 1'b1) begin
            lat  = n;
            seen = 1;
            break;
         end
      end
      start = 1'b0;
      if (!seen) begin
         total++;
         bad++;
         $display("FAIL %s_timeout: got no done expected done within 40 cycles", name);
      end else begin
         check({name, "_latency"}, 32'(lat), 32'd10);
         check({name, "_busy_cycles"}, 32'(busy_cnt), 32'd8);
         @(negedge clock);
         check({name, "_done_single"}, 32'(done), 32'd0);
         check({name, "_result_hold"}, 32'(result), 32'(er));
      end
   endtask

   initial begin
      int pulses_before;
      reset    = 1'b1;
      start    = 1'b0;
      subtract = 1'b0;
      a        = 8'h00;
      b        = 8'h00;
      repeat (3) @(posedge clock);
      #1;
      reset = 1'b0;
      @(negedge clock);
      check("reset_state", {busy, done, result, carryOut, overflow, zero}, 13'h0);

      run_op("add_35_4a", 8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0, 1'b0, 1'b0, 0);
      run_op("add_7f_01", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0, 0);
      run_op("add_ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 0);
      run_op("sub_10_20", 8'h10, 8'h20, 1'b1, 8'hF0, 1'b0, 1'b0, 1'b0, 0);
      run_op("sub_20_20", 8'h20, 8'h20, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1, 0);
      run_op("sub_80_01", 8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1, 1'b0, 0);
      run_op("sub_05_03", 8'h05, 8'h03, 1'b1, 8'h02, 1'b1, 1'b0, 1'b0, 0);
      run_op("busy_start", 8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0, 3);
      run_op("done_start", 8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0, 1'b0, 9);

      // Mid-op reset: no expected entry is pushed, so any done is reported.
      pulses_before = done_pulses;
      @(posedge clock);
      #1;
      start    = 1'b1;
      a        = 8'h55;
      b        = 8'h0A;
      subtract = 1'b0;
      @(posedge clock);
      #1;
      start = 1'b0;
      repeat (3) @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      check("midop_reset_state", {busy, done, result, carryOut, overflow, zero}, 13'h0);
      repeat (20) @(negedge clock);
      check("midop_reset_no_done", 32'(done_pulses), 32'(pulses_before));

      run_op("after_reset", 8'h03, 8'h04, 1'b0, 8'h07, 1'b0, 1'b0, 1'b0, 0);

      repeat (30) @(negedge clock);
      check("scoreboard_empty", 32'(sb.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
